// File: rtl/branch_predict_unit.sv
// Early branch predictor: combinational next-PC from IF flags plus a 2-bit BHT,
// with EX-time table training and a registered mispredict redirect.
module branch_predict_unit #(
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_jal,
  input  logic             if_jalr,
  input  logic             if_btype,
  input  logic [31:0]      if_imme,
  output logic             pred_taken,
  output logic [31:0]      pred_pc,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_btype,
  input  logic             ex_jalr,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int ENTRIES = 1 << INDEX_W;

  logic [1:0]         bht [ENTRIES];
  logic [INDEX_W-1:0] if_idx, ex_idx;
  logic [31:0]        if_seq, if_tgt, ex_seq;
  logic               mp;

  assign if_idx = if_pc[INDEX_W+1:2];
  assign ex_idx = ex_pc[INDEX_W+1:2];
  assign if_seq = if_pc + 32'd4;
  assign if_tgt = if_pc + if_imme;
  assign ex_seq = ex_pc + 32'd4;

  // JALR target is unknown at IF, so it falls through to the sequential PC.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = if_seq;
    if (if_valid) begin
      if (if_jal) begin
        pred_taken = 1'b1;
        pred_pc    = if_tgt;
      end else if (if_btype) begin
        pred_taken = bht[if_idx][1];
        pred_pc    = bht[if_idx][1] ? if_tgt : if_seq;
      end
    end
  end

  assign mp = ex_valid && ((ex_btype && (ex_taken != ex_pred_taken)) ||
                           (ex_jalr && (ex_target != ex_seq)));

  // No write bypass: an IF lookup colliding with an update sees the old count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
    end else if (ex_valid && ex_btype) begin
      if (ex_taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
      mispred_cnt <= '0;
    end else begin
      redirect <= mp;
      if (mp) begin
        redirect_pc <= ex_taken ? ex_target : ex_seq;
        if (mispred_cnt != {CNT_W{1'b1}}) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: IF predictions checked against a BHT
// model, redirect/counter results checked through an expectation queue.
module tb_branch_predict_unit;
  localparam int INDEX_W = 6;
  localparam int CNT_W   = 5;

  typedef struct packed {
    logic             red;
    logic [31:0]      pc;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic if_valid = 0, if_jal = 0, if_jalr = 0, if_btype = 0;
  logic [31:0] if_pc = 0, if_imme = 0;
  logic pred_taken;
  logic [31:0] pred_pc;
  logic ex_valid = 0, ex_btype = 0, ex_jalr = 0, ex_taken = 0, ex_pred_taken = 0;
  logic [31:0] ex_pc = 0, ex_target = 0;
  logic redirect;
  logic [31:0] redirect_pc;
  logic [CNT_W-1:0] mispred_cnt;

  int tests = 0, fails = 0;
  exp_t q[$];
  logic [1:0]       bht_m [1 << INDEX_W];
  logic [31:0]      exp_rpc;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  branch_predict_unit #(.INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc), .if_jal(if_jal), .if_jalr(if_jalr),
    .if_btype(if_btype), .if_imme(if_imme),
    .pred_taken(pred_taken), .pred_pc(pred_pc),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_btype(ex_btype), .ex_jalr(ex_jalr),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .redirect(redirect), .redirect_pc(redirect_pc), .mispred_cnt(mispred_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << INDEX_W); i++) bht_m[i] = 2'b01;
    exp_rpc = 32'd0;
    exp_cnt = '0;
    q.delete();
  endtask

  // Drive IF flags, then compare the zero-latency prediction against the model.
  task automatic pred(input string tag, input logic v, input logic jal, input logic jalr,
                      input logic bt, input logic [31:0] pc, input logic [31:0] imm);
    logic et;
    logic [31:0] ep;
    if_valid = v; if_jal = jal; if_jalr = jalr; if_btype = bt; if_pc = pc; if_imme = imm;
    #1;
    et = 1'b0;
    if (v && jal) et = 1'b1;
    else if (v && bt) et = bht_m[pc[INDEX_W+1:2]][1];
    ep = et ? pc + imm : pc + 32'd4;
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, et});
    chk({tag, "_pc"}, pred_pc, ep);
  endtask

  task automatic ex_drive(input logic v, input logic bt, input logic jalr, input logic tk,
                          input logic ptk, input logic [31:0] pc, input logic [31:0] tgt);
    logic m;
    exp_t e;
    ex_valid = v; ex_btype = bt; ex_jalr = jalr; ex_taken = tk; ex_pred_taken = ptk;
    ex_pc = pc; ex_target = tgt;
    m = v && ((bt && (tk != ptk)) || (jalr && (tgt != pc + 32'd4)));
    if (m) begin
      exp_rpc = tk ? tgt : pc + 32'd4;
      if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    end
    e.red = m; e.pc = exp_rpc; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic ex_clk(input string tag);
    exp_t e;
    @(posedge clk);
    if (ex_valid && ex_btype) begin
      if (ex_taken && bht_m[ex_pc[INDEX_W+1:2]] != 2'b11)
        bht_m[ex_pc[INDEX_W+1:2]] = bht_m[ex_pc[INDEX_W+1:2]] + 2'b01;
      else if (!ex_taken && bht_m[ex_pc[INDEX_W+1:2]] != 2'b00)
        bht_m[ex_pc[INDEX_W+1:2]] = bht_m[ex_pc[INDEX_W+1:2]] - 2'b01;
    end
    #1;
    ex_valid = 1'b0;
    e = q.pop_front();
    chk({tag, "_redirect"}, {31'd0, redirect}, {31'd0, e.red});
    chk({tag, "_rpc"}, redirect_pc, e.pc);
    chk({tag, "_cnt"}, 32'(mispred_cnt), 32'(e.cnt));
  endtask

  task automatic ex_step(input string tag, input logic bt, input logic jalr, input logic tk,
                         input logic ptk, input logic [31:0] pc, input logic [31:0] tgt);
    ex_drive(1'b1, bt, jalr, tk, ptk, pc, tgt);
    ex_clk(tag);
  endtask

  task automatic idle(input string tag);
    ex_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    ex_clk(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_cnt", 32'(mispred_cnt), 32'd0);

    pred("br_cold", 1, 0, 0, 1, 32'h100, 32'h20);
    chk("br_cold_const", pred_pc, 32'h104);
    pred("jal", 1, 1, 0, 0, 32'h200, 32'hFFFF_FFF0);
    chk("jal_const", pred_pc, 32'h1F0);
    pred("invalid", 0, 1, 0, 0, 32'h200, 32'h40);
    pred("jalr_if", 1, 0, 1, 0, 32'h240, 32'h40);
    pred("noflag", 1, 0, 0, 0, 32'h280, 32'h40);
    pred("prio_jal", 1, 1, 1, 1, 32'h2C0, 32'h80);
    pred("wrap", 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0);

    // Two taken mispredicts at 0x100 train the counter 01 -> 10 -> 11.
    ex_step("mp1", 1, 0, 1, 0, 32'h100, 32'h120);
    ex_step("mp2", 1, 0, 1, 0, 32'h100, 32'h120);
    chk("mp2_cnt_const", 32'(mispred_cnt), 32'd2);
    idle("mp_idle");
    pred("br_trained", 1, 0, 0, 1, 32'h100, 32'h20);
    chk("br_trained_pc", pred_pc, 32'h120);
    ex_step("nt_ok", 1, 0, 0, 0, 32'h180, 32'h200);
    pred("br_strong_nt", 1, 0, 0, 1, 32'h180, 32'h40);

    ex_step("jalr_ok", 0, 1, 1, 0, 32'h300, 32'h304);
    ex_step("jalr_mp", 0, 1, 1, 0, 32'h300, 32'h500);
    idle("jalr_idle");
    ex_step("b2b_a", 1, 0, 0, 1, 32'h104, 32'h400);
    ex_step("b2b_b", 0, 1, 1, 0, 32'h308, 32'h600);
    idle("b2b_idle");

    for (int i = 0; i < 35; i++) ex_step("sat", 0, 1, 1, 0, 32'h300, 32'h700 + 32'(i * 4));
    chk("sat_cnt", 32'(mispred_cnt), 32'h1F);

    // Reset while a redirect pulse is being presented.
    ex_step("pre_rst", 1, 0, 1, 0, 32'h140, 32'h900);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_redirect", {31'd0, redirect}, 32'd0);
    chk("arst_rpc", redirect_pc, 32'd0);
    chk("arst_cnt", 32'(mispred_cnt), 32'd0);
    model_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < (1 << INDEX_W); i++)
      pred("bht_rst", 1, 0, 0, 1, 32'(i * 4), 32'h10);

    // Collision: lookup and update of the same 01 entry in one cycle.
    ex_drive(1, 1, 0, 1, 0, 32'h100, 32'h120);
    pred("coll_old", 1, 0, 0, 1, 32'h100, 32'h20);
    chk("coll_old_const", {31'd0, pred_taken}, 32'd0);
    ex_clk("coll");
    pred("coll_new", 1, 0, 0, 1, 32'h100, 32'h20);
    chk("coll_new_const", {31'd0, pred_taken}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Consumer end of the front-end early-decode interface: takes the IF-stage jump/branch flags and immediate, predicts next PC.
- Owns a 2-bit saturating branch history table (BHT), updated at EX resolution.
- Issues a registered redirect to the PC mux on mispredict; counts mispredicts.

Parameters:
- INDEX_W, 6, BHT index width; table holds 2^INDEX_W entries.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_valid  input  1  IF stage holds a valid instruction
- if_pc  input  32  PC of the IF instruction
- if_jal  input  1  IF instruction is JAL
- if_jalr  input  1  IF instruction is JALR
- if_btype  input  1  IF instruction is a conditional branch
- if_imme  input  32  sign-extended J/B immediate, byte offset, bit0 = 0
- pred_taken  output  1  combinational: fetch redirected to pred_pc
- pred_pc  output  32  combinational predicted next PC
- ex_valid  input  1  EX stage holds a resolved control-flow instruction
- ex_pc  input  32  PC of the EX instruction
- ex_btype  input  1  EX instruction is a conditional branch
- ex_jalr  input  1  EX instruction is JALR
- ex_taken  input  1  actual branch outcome (1 for JALR)
- ex_target  input  32  actual taken target
- ex_pred_taken  input  1  pred_taken carried down the pipe with this instruction
- redirect  output  1  registered one-cycle pulse: flush and load redirect_pc
- redirect_pc  output  32  registered corrected PC
- mispred_cnt  output  CNT_W  saturating mispredict count

Behaviour:
- Index = pc[INDEX_W+1:2], for both IF lookup and EX update.
- Reset (async, rst_n=0):
  - every BHT entry = 2'b01 (weakly not-taken);
  - redirect = 0, redirect_pc = 0, mispred_cnt = 0.
  - Reset asserted mid-operation discards any pending redirect immediately.
- Prediction is combinational, zero latency, priority order:
  - !if_valid: pred_taken = 0, pred_pc = if_pc+4.
  - if_jal: pred_taken = 1, pred_pc = if_pc+if_imme.
  - if_btype: pred_taken = BHT[idx][1]; pred_pc = taken ? if_pc+if_imme : if_pc+4.
  - if_jalr, or no flag set: pred_taken = 0, pred_pc = if_pc+4 (JALR target is unknown at IF).
  - All adds are 32-bit modulo; wrap past 0xFFFF_FFFC is not flagged.
- BHT update, on the clock edge when ex_valid && ex_btype:
  - ex_taken: counter increments, saturating at 2'b11.
  - !ex_taken: counter decrements, saturating at 2'b00.
  - No update for JALR/JAL.
- Same-cycle read/write to the same index: IF sees the old value; the new value is visible next cycle (no bypass).
- Mispredict condition, mp:
  - ex_valid && ex_btype && (ex_taken != ex_pred_taken), or
  - ex_valid && ex_jalr && (ex_target != ex_pc+4).
- Redirect, one cycle after the EX cycle:
  - redirect <= mp.
  - If mp: redirect_pc <= ex_taken ? ex_target : ex_pc+4. Otherwise redirect_pc holds its value.
  - redirect is high exactly one cycle per mispredict. Back-to-back EX mispredicts give back-to-back pulses, each with its own PC.
- mispred_cnt increments on each mp and saturates at all-ones.
- Flags are assumed one-hot. If several are set, the priority above applies.

Test Plan:
- Reset then if_valid=1, if_btype=1, if_pc=0x100, if_imme=0x20 -> pred_taken=0, pred_pc=0x104; mispred_cnt=0, redirect=0.
- if_jal=1, if_pc=0x200, if_imme=0xFFFF_FFF0 -> pred_taken=1, pred_pc=0x1F0 in the same cycle.
- Two EX updates at ex_pc=0x100, ex_btype=1, ex_taken=1, ex_pred_taken=0 -> redirect pulses the cycle after each, redirect_pc=ex_target both times, mispred_cnt=2; IF lookup at 0x100 then gives pred_taken=1, pred_pc=0x120.
- Same-cycle collision: if_pc=ex_pc=0x100 with a counter at 01 being incremented -> pred_taken=0 that cycle, 1 next cycle.
- JALR checks:
  - ex_jalr=1, ex_pc=0x300, ex_target=0x304 -> no redirect.
  - ex_target=0x500 -> redirect=1, redirect_pc=0x500 for exactly one cycle.
- Saturation: force mispred_cnt to 0xFFFF with a further mispredict -> it stays at 0xFFFF. Assert rst_n=0 during the redirect-pending cycle -> redirect=0 immediately and all BHT entries read 01 afterwards.
